dcache_2way: RTL and testbench
==============================

# dcache_2way

Parametrised two-way set-associative data cache, successor to the direct-mapped dcache, sitting between the MEM stage and the multicycle memory. Write-through with write-allocate and 16-byte blocks of 16-bit words. Per-set LRU replacement, with an invalid way filled first. An integrated pipelined fill engine requests all block words back-to-back and holds `stall` until the block is resident.

## Interface
- `ADDR_W`, 16: byte address width.
- `DATA_W`, 16: word width.
- `SETS`, 64: sets per way; power of two, ≥2. Index = `req_addr[3+log2(SETS):4]`; tag = remaining upper bits.
- `WORDS`, 8: words per block; fixed at 8 for this generation (offset = `addr[3:1]`).

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1  access request this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W  byte address; bit 0 ignored.
- `req_wdata`  in  DATA_W  store data.
- `rd_data`  out  DATA_W  load data on hit, else 0.
- `stall`  out  1  pipeline must hold the request unchanged.
- `mem_rd`  out  1  fill word read request.
- `mem_wr`  out  1  write-through pulse, one cycle per store.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  = `req_wdata`.
- `mem_data_valid`  in  1  `mem_rdata` carries next fill word, in request order.
- `mem_rdata`  in  DATA_W  fill data.

## Operation
- Hit: `req_valid` and some way has valid=1 with matching tag; both ways are looked up combinationally.
- Load hit: `rd_data` = word from hit way; set LRU ← other way.
- Store hit: word written at edge; `mem_wr`=1 with `mem_addr`=`req_addr`; LRU updated.
- Miss: `stall`=1 combinationally; FSM IDLE→FILL.
- Victim selection, latched on entry to FILL: way 0 if invalid, else way 1 if invalid, else LRU way.
- Victim valid is cleared on entry to FILL.
- FILL issue: counter `iss` 0..7; `mem_rd`=1 and `mem_addr`={block base, iss, 1'b0} for 8 consecutive cycles.
- FILL receive: counter `rcv` 0..7; each `mem_data_valid` writes `mem_rdata` to victim word `rcv`.
- 8th receive: writes tag, sets valid and LRU ← other way; FSM → IDLE.
- The held request then re-evaluates as a hit and completes normally; stores write-through at that point.
- `mem_data_valid` is ignored in IDLE and after `rcv` reaches 8.
- `mem_rd` and `mem_wr` are never asserted in the same cycle.
- `mem_addr` is 0 when neither strobe is asserted.
- Counters are log2(WORDS) bits wide; wrap is suppressed by the saturating done flags.
- Reset (any cycle, including mid-fill): all valid and LRU bits cleared; FSM IDLE; counters 0; the partial fill is abandoned.
- Outputs during the reset cycle: `stall`=0, `mem_rd`=0, `mem_wr`=0, `rd_data`=0.

## Timing
- Hit latency: 0 cycles; data is combinational in the request cycle.
- Miss detected in cycle 0. Issue occurs in cycles 1–8; word k returns in cycle 1+k+L for memory latency L.
- Tag write: end of cycle 8+L; hit in cycle 9+L.
- `stall` high for 9+L cycles (13 at L=4).
- A returned word may arrive in the same cycle as an issue; both are handled.

## Configuration
- `DCACHE_PERF_CNT_EN` defined: adds 16-bit saturating outputs `hit_cnt` and `miss_cnt`, both reset to 0.
  - `hit_cnt` increments on each completed hit with `stall`=0.
  - `miss_cnt` increments on each IDLE→FILL transition.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package `dcache_pkg`:
  - FSM state enum (IDLE, FILL).
  - Offset width constant (3).
  - `clog2`-derived index/tag width functions.
  - Tag/valid struct.
- Sub-module `dcache_way`, instantiated twice: data array plus tag/valid array for one way, with combinational read, per-word write enable and synchronous clear.
- LRU bit vector and FSM live in the top level.

## Test plan
- Cold load 0x1234, L=4:
  - `stall` high 13 cycles.
  - `mem_rd` addresses 0x1230..0x123E, one per cycle.
  - Then `rd_data` = word 2 of block.
- Load 0x1234 again: hit, `stall`=0, same data, no `mem_rd`.
- Conflict on set of 0x1234:
  - Load 0x1634 fills way 1.
  - Load 0x1234 hits way 0.
  - Load 0x1A34 evicts way 1 (LRU).
  - Load 0x1634 then misses.
- Store miss 0x2000 data 0xBEEF:
  - Fill completes, then one `mem_wr` with 0x2000/0xBEEF.
  - Subsequent load of 0x2000 returns 0xBEEF.
- `rst_n` low at fill cycle 5:
  - Next cycle IDLE, `mem_rd`=0, stray `mem_data_valid` ignored.
  - Reload of 0x1234 misses.
- With `DCACHE_PERF_CNT_EN`: after the first two scenarios, `hit_cnt`=2 and `miss_cnt`=1 (the post-fill hit counts).

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the two-way set-associative data cache.
// Contents: FSM state enum, block offset width, index/tag width helpers and the
// tag/valid record returned by each way on lookup.
package dcache_pkg;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  // Word offset within a 16-byte block of 16-bit words (addr[3:1]).
  localparam int OFF_W = 3;

  // Widest tag a way can report; narrower tags are zero-extended into it.
  localparam int TAG_MAX_W = 32;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  // Tag = address bits above byte-in-word, word offset and index.
  function automatic int tag_w(input int addr_w, input int sets);
    return addr_w - OFF_W - 1 - $clog2(sets);
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
  } tagv_t;

endpackage

// File: rtl/dcache_way.sv
// dcache_way: one way of the cache -- data array plus tag/valid array.
// Ports:
//   clk, rst_n   clock; synchronous active-low clear of all valid bits
//   i_idx/i_off  set index and word offset used for both read and write
//   o_data       combinational word read; o_tagv  tag/valid of set i_idx
//   i_we/i_wdata per-word write enable and data
//   i_tag_we     writes i_tag and sets valid for set i_idx
//   i_inv        clears valid for set i_idx (victim invalidation)
module dcache_way
  import dcache_pkg::*;
#(
  parameter int SETS   = 64,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 6,
  parameter int IDX_W  = idx_w(SETS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [OFF_W-1:0]  i_off,
  output logic [DATA_W-1:0] o_data,
  output tagv_t             o_tagv,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_tag_we,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_inv
);

  logic [DATA_W-1:0]      r_data [SETS*8];
  logic [TAG_W-1:0]       r_tag  [SETS];
  logic [SETS-1:0]        r_valid;
  logic [IDX_W+OFF_W-1:0] w_waddr;

  assign w_waddr = {i_idx, i_off};
  assign o_data  = r_data[w_waddr];

  // Tag/valid lookup, tag zero-extended to the package-wide width.
  always_comb begin
    o_tagv            = '0;
    o_tagv.valid      = r_valid[i_idx];
    o_tagv.tag[TAG_W-1:0] = r_tag[i_idx];
  end

  // Data array word write.
  always_ff @(posedge clk) begin
    if (i_we) r_data[w_waddr] <= i_wdata;
  end

  // Tag array write on fill completion.
  always_ff @(posedge clk) begin
    if (i_tag_we) r_tag[i_idx] <= i_tag;
  end

  // Valid bits: cleared by reset, set on fill completion, cleared on victim selection.
  always_ff @(posedge clk) begin
    if (!rst_n)        r_valid <= '0;
    else if (i_tag_we) r_valid[i_idx] <= 1'b1;
    else if (i_inv)    r_valid[i_idx] <= 1'b0;
  end

endmodule

// File: rtl/dcache_2way.sv
// dcache_2way: write-through, write-allocate two-way set-associative data cache
// with per-set LRU and a pipelined 8-word block fill engine.
// Ports: clk/rst_n (sync active-low); req_valid/req_write/req_addr/req_wdata from
// MEM stage; rd_data (load hit data, else 0); stall; mem_rd/mem_wr/mem_addr/
// mem_wdata to memory; mem_data_valid/mem_rdata fill return.
// Optional macro DCACHE_PERF_CNT_EN adds saturating hit_cnt/miss_cnt outputs.
module dcache_2way
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int SETS   = 64,
  parameter int WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              stall,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(ADDR_W, SETS);
  localparam int CNT_W = $clog2(WORDS);

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_iss, r_rcv;
  logic                r_iss_done, r_rcv_done, r_victim;
  logic [SETS-1:0]     r_lru;  // per set: the least recently used way
  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [OFF_W-1:0]    w_off, w_way_off;
  tagv_t               w_tv0, w_tv1;
  logic [DATA_W-1:0]   w_rd0, w_rd1, w_wdata;
  logic                w_hit0, w_hit1, w_hit, w_access, w_miss;
  logic                w_rcv_fire, w_rcv_last, w_victim_new;
  logic                w_we0, w_we1, w_tag_we0, w_tag_we1, w_inv0, w_inv1;

  assign w_idx = req_addr[OFF_W+IDX_W:OFF_W+1];
  assign w_tag = req_addr[ADDR_W-1:OFF_W+1+IDX_W];
  assign w_off = req_addr[OFF_W:1];

  assign w_hit0 = req_valid & w_tv0.valid & (w_tv0.tag == TAG_MAX_W'(w_tag));
  assign w_hit1 = req_valid & w_tv1.valid & (w_tv1.tag == TAG_MAX_W'(w_tag));
  assign w_hit  = w_hit0 | w_hit1;

  assign w_access   = rst_n & (r_state == IDLE) & w_hit;
  assign w_miss     = rst_n & (r_state == IDLE) & req_valid & ~w_hit;
  assign w_rcv_fire = rst_n & (r_state == FILL) & mem_data_valid & ~r_rcv_done;
  assign w_rcv_last = w_rcv_fire & (r_rcv == CNT_W'(WORDS - 1));

  // Invalid way 0 first, then invalid way 1, otherwise the LRU way.
  assign w_victim_new = ~w_tv0.valid ? 1'b0 : (~w_tv1.valid ? 1'b1 : r_lru[w_idx]);

  // The request is held during a fill, so its index also addresses the victim.
  assign w_way_off = (r_state == FILL) ? w_off_fill(r_rcv) : w_off;
  assign w_wdata   = (r_state == FILL) ? mem_rdata : req_wdata;
  assign w_we0     = (w_access & req_write & w_hit0) | (w_rcv_fire & ~r_victim);
  assign w_we1     = (w_access & req_write & w_hit1) | (w_rcv_fire &  r_victim);
  assign w_tag_we0 = w_rcv_last & ~r_victim;
  assign w_tag_we1 = w_rcv_last &  r_victim;
  assign w_inv0    = w_miss & ~w_victim_new;
  assign w_inv1    = w_miss &  w_victim_new;
  assign mem_wdata = req_wdata;

  function automatic logic [OFF_W-1:0] w_off_fill(input logic [CNT_W-1:0] c);
    return OFF_W'(c);
  endfunction

  dcache_way #(.SETS(SETS), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_way0 (
    .clk(clk), .rst_n(rst_n), .i_idx(w_idx), .i_off(w_way_off), .o_data(w_rd0),
    .o_tagv(w_tv0), .i_we(w_we0), .i_wdata(w_wdata), .i_tag_we(w_tag_we0),
    .i_tag(w_tag), .i_inv(w_inv0)
  );

  dcache_way #(.SETS(SETS), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_way1 (
    .clk(clk), .rst_n(rst_n), .i_idx(w_idx), .i_off(w_way_off), .o_data(w_rd1),
    .o_tagv(w_tv1), .i_we(w_we1), .i_wdata(w_wdata), .i_tag_we(w_tag_we1),
    .i_tag(w_tag), .i_inv(w_inv1)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state: miss starts a fill, eighth returned word ends it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_miss ? FILL : IDLE;
      FILL:    w_state_nxt = w_rcv_last ? IDLE : FILL;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs; everything is forced quiet while reset is asserted.
  always_comb begin
    stall    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = '0;
    rd_data  = '0;
    if (rst_n) begin
      case (r_state)
        IDLE: begin
          stall = req_valid & ~w_hit;
          if (w_hit && req_write) begin
            mem_wr   = 1'b1;
            mem_addr = req_addr;
          end else if (w_hit) begin
            rd_data = w_hit1 ? w_rd1 : w_rd0;
          end else begin
            rd_data = '0;
          end
        end
        FILL: begin
          stall = 1'b1;
          if (!r_iss_done) begin
            mem_rd   = 1'b1;
            mem_addr = {req_addr[ADDR_W-1:OFF_W+1], r_iss, 1'b0};
          end else begin
            mem_rd = 1'b0;
          end
        end
        default: stall = 1'b0;
      endcase
    end else begin
      stall = 1'b0;
    end
  end

  // Fill engine: victim latch plus saturating issue/receive counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_iss      <= '0;
      r_rcv      <= '0;
      r_iss_done <= 1'b0;
      r_rcv_done <= 1'b0;
      r_victim   <= 1'b0;
    end else if (w_miss) begin
      r_victim   <= w_victim_new;
      r_iss      <= '0;
      r_rcv      <= '0;
      r_iss_done <= 1'b0;
      r_rcv_done <= 1'b0;
    end else if (r_state == FILL) begin
      if (!r_iss_done) begin
        if (r_iss == CNT_W'(WORDS - 1)) r_iss_done <= 1'b1;
        else                            r_iss      <= r_iss + CNT_W'(1);
      end
      if (w_rcv_fire) begin
        if (w_rcv_last) r_rcv_done <= 1'b1;
        else            r_rcv      <= r_rcv + CNT_W'(1);
      end
    end
  end

  // LRU: point at the way not just used (hit) or not just filled.
  always_ff @(posedge clk) begin
    if (!rst_n)          r_lru <= '0;
    else if (w_access)   r_lru[w_idx] <= ~w_hit1;
    else if (w_rcv_last) r_lru[w_idx] <= ~r_victim;
  end

`ifdef DCACHE_PERF_CNT_EN
  // Saturating hit/miss event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= 16'd0;
      miss_cnt <= 16'd0;
    end else begin
      if (w_access && hit_cnt != 16'hFFFF) hit_cnt  <= hit_cnt + 16'd1;
      if (w_miss && miss_cnt != 16'hFFFF)  miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_2way.sv
// Scoreboard bench for dcache_2way: driver pushes expectations from a block-residency
// reference model, a negedge monitor pops and compares; a latency-L memory serves fills.
module tb_dcache_2way;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [15:0] req_addr = 16'h0, req_wdata = 16'h0;
  logic [15:0] rd_data, mem_addr, mem_wdata;
  logic        stall, mem_rd, mem_wr;
  logic        mem_data_valid = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
`ifdef DCACHE_PERF_CNT_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  dcache_2way dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rd_data(rd_data), .stall(stall),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata)
`ifdef DCACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic w; logic [15:0] a; logic [15:0] rdata; int stalls; } exp_t;
  typedef struct { logic [15:0] a; logic [15:0] d; } wr_t;
  typedef struct { logic [15:0] a; int due; } pend_t;

  exp_t        sb_q[$];
  wr_t         wr_q[$];
  logic [15:0] fill_q[$];
  pend_t       pend_q[$];
  int total = 0, bad = 0, cyc = 0, lat = 4, stall_cnt = 0;

  // Reference: per set, resident block numbers in recency order (index 0 = MRU).
  logic [11:0] res_blk [64][2];
  int          res_n [64];
  logic [15:0] ref_mem [int];
  logic [15:0] env_mem [int];

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return (a ^ 16'hC3A5) + {a[7:0], a[15:8]};
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    int k = int'({a[15:1], 1'b0});
    return ref_mem.exists(k) ? ref_mem[k] : init_word(16'(k));
  endfunction

  function automatic logic [15:0] env_read(input logic [15:0] a);
    int k = int'({a[15:1], 1'b0});
    return env_mem.exists(k) ? env_mem[k] : init_word(16'(k));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory: latch fill requests, return each L cycles later; absorb write-throughs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd) pend_q.push_back('{mem_addr, cyc + lat});
      if (mem_wr) env_mem[int'({mem_addr[15:1], 1'b0})] = mem_wdata;
    end
  end

  always @(posedge clk) begin
    pend_t p;
    cyc = cyc + 1;
    #1;
    mem_data_valid = 1'b0;
    mem_rdata = 16'($urandom);
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      mem_data_valid = 1'b1;
      mem_rdata = env_read(p.a);
    end
  end

  // Monitor: compares every strobe and every completed request against the queues.
  always @(negedge clk) begin
    exp_t e;
    wr_t  w;
    if (rst_n) begin
      chk("rd_wr_exclusive", {31'b0, mem_rd & mem_wr}, 32'd0);
      if (!mem_rd && !mem_wr) chk("mem_addr_idle", {16'b0, mem_addr}, 32'd0);
      if (mem_rd) begin
        if (fill_q.size() == 0) chk("unexpected_mem_rd", {16'b0, mem_addr}, 32'hFFFF_FFFF);
        else chk("fill_addr", {16'b0, mem_addr}, {16'b0, fill_q.pop_front()});
      end
      if (mem_wr) begin
        if (wr_q.size() == 0) chk("unexpected_mem_wr", {16'b0, mem_addr}, 32'hFFFF_FFFF);
        else begin
          w = wr_q.pop_front();
          chk("wt_addr", {16'b0, mem_addr}, {16'b0, w.a});
          chk("wt_data", {16'b0, mem_wdata}, {16'b0, w.d});
          chk("wt_no_stall", {31'b0, stall}, 32'd0);
        end
      end
      if (req_valid && stall) begin
        stall_cnt++;
        chk("rd_data_during_stall", {16'b0, rd_data}, 32'd0);
      end else if (req_valid) begin
        if (sb_q.size() == 0) chk("unexpected_completion", {16'b0, req_addr}, 32'hFFFF_FFFF);
        else begin
          e = sb_q.pop_front();
          chk("stall_cycles", stall_cnt, e.stalls);
          if (!e.w) chk("load_data", {16'b0, rd_data}, {16'b0, e.rdata});
        end
        stall_cnt = 0;
      end else begin
        stall_cnt = 0;
      end
    end else begin
      stall_cnt = 0;
    end
  end

  // Model one access (residency + expectations), then drive it until it completes.
  task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d);
    exp_t        e;
    logic [11:0] blk, tmp;
    int          s;
    bit          hit, done;
    blk = a[15:4];
    s   = int'(a[9:4]);
    hit = 1'b0;
    if (res_n[s] > 0 && res_blk[s][0] == blk) hit = 1'b1;
    else if (res_n[s] > 1 && res_blk[s][1] == blk) begin
      hit = 1'b1;
      tmp = res_blk[s][0];
      res_blk[s][0] = blk;
      res_blk[s][1] = tmp;
    end else begin
      res_blk[s][1] = res_blk[s][0];
      res_blk[s][0] = blk;
      if (res_n[s] < 2) res_n[s]++;
      for (int i = 0; i < 8; i++) fill_q.push_back({a[15:4], 4'h0} + 16'(2 * i));
    end
    e.w = w;
    e.a = a;
    e.stalls = hit ? 0 : 9 + lat;
    e.rdata = w ? 16'h0 : ref_read(a);
    if (w) begin
      ref_mem[int'({a[15:1], 1'b0})] = d;
      wr_q.push_back('{a, d});
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
    end
    if (!done) chk("request_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) res_n[i] = 0;
    // Reset cycle with a live store request: outputs must stay quiet.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h1234; req_wdata = 16'hAAAA;
    @(negedge clk);
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("reset_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("reset_rd_data", {16'b0, rd_data}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 1'b0;

    lat = 4;
    do_req(1'b0, 16'h1234, 16'h0);   // cold miss: 13 stall cycles
    do_req(1'b0, 16'h1234, 16'h0);   // hit
    idle(0);
`ifdef DCACHE_PERF_CNT_EN
    @(negedge clk);
    chk("hit_cnt", {16'b0, hit_cnt}, 32'd2);
    chk("miss_cnt", {16'b0, miss_cnt}, 32'd1);
`endif
    do_req(1'b0, 16'h1634, 16'h0);   // fills way 1
    do_req(1'b0, 16'h1234, 16'h0);   // hits way 0
    do_req(1'b0, 16'h1A34, 16'h0);   // evicts 0x1634
    do_req(1'b0, 16'h1634, 16'h0);   // misses again
    do_req(1'b1, 16'h2000, 16'hBEEF); // store miss, then write-through
    do_req(1'b0, 16'h2000, 16'h0);
    idle(2);

    // Reset in fill cycle 5; stale returns must be ignored afterwards.
    for (int i = 0; i < 8; i++) fill_q.push_back(16'h7770 + 16'(2 * i));
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h7770;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("midfill_reset_stall", {31'b0, stall}, 32'd0);
    chk("midfill_reset_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("midfill_reset_rd_data", {16'b0, rd_data}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fill_q.delete();
    for (int i = 0; i < 64; i++) res_n[i] = 0;
    @(negedge clk);
    chk("post_reset_mem_rd", {31'b0, mem_rd}, 32'd0);
    repeat (12) @(posedge clk);
    do_req(1'b0, 16'h1234, 16'h0);   // must miss after reset

    // Randomised traffic over a few sets and tags to provoke conflicts.
    for (int n = 0; n < 80; n++) begin
      int t, s, o, b;
      t = $urandom_range(0, 3);
      s = $urandom_range(0, 1);
      o = $urandom_range(0, 7);
      b = $urandom_range(0, 1);
      lat = $urandom_range(1, 6);
      do_req(1'($urandom_range(0, 1)), 16'((t << 10) | (s << 4) | (o << 1) | b),
             16'($urandom));
    end
    idle(20);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    chk("fill_queue_drained", fill_q.size(), 32'd0);
    chk("write_queue_drained", wr_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
